xadc_channel_scanner: RTL and testbench
=======================================

Name: xadc_channel_scanner

Overview:
Parametrised multi-channel successor to the single-value XADC readout path. Scans a masked set of up to 16 XADC auxiliary channels over the DRP port and keeps the latest 12-bit result per channel in a register bank. Emits {channel, value} records on a valid/ready stream for the UART formatter. Offers a registered readback port for the seven-segment and VGA text paths.

Parameters:
NUM_CH, 16, number of channel slots; channel i maps to DRP address 7'h10+i
CH_MASK, 16'h1FFF, bit i=1 includes channel i in the scan; default is 13 channels
TIMEOUT, 255, maximum cycles to wait for drdy before abandoning a read
AVG_LOG2, 2, log2 of the averaging depth; used only with VOLTMETER_AVG_EN

Ports:
clk  in  1  system clock, 100 MHz domain
rst  in  1  asynchronous, active-low reset
scan_start  in  1  one-cycle pulse that starts a scan; tie to XADC eos
drp_daddr  out  7  DRP address
drp_den  out  1  DRP enable, one-cycle pulse
drp_dwe  out  1  DRP write enable; constant 0
drp_do  in  16  DRP read data; result is in bits [15:4]
drp_drdy  in  1  DRP data ready
out_valid  out  1  record valid
out_ready  in  1  record accepted by the sink
out_ch  out  4  channel index of the record
out_data  out  12  channel value of the record
rd_ch  in  4  readback channel select
rd_data  out  12  bank[rd_ch], 1-cycle latency
busy  out  1  high whenever the FSM is not in IDLE
err_timeout  out  1  sticky flag; set on any DRP timeout; cleared only by reset

Behaviour:
- Reset: all outputs 0, bank entries 0, FSM in IDLE, pending flag 0, channel pointer 0.
- FSM states: IDLE, FIND, ISSUE, WAIT, STORE, EMIT.
- IDLE: on scan_start or pending set, clear pending and go to FIND with pointer 0.
- FIND: advance the pointer to the next index i with CH_MASK[i]=1. Cost is one cycle per index examined. If the pointer passes NUM_CH-1, return to IDLE.
- ISSUE: drive drp_den=1 for exactly one cycle with drp_daddr=7'h10+ptr. Clear the timeout counter. Go to WAIT.
- WAIT: on drp_drdy, capture drp_do[15:4] and go to STORE.
  - If the counter reaches TIMEOUT without drp_drdy, set err_timeout, leave the bank entry unchanged, increment the pointer, go to FIND. No record is emitted.
- STORE: write the captured value into bank[ptr]. Go to EMIT.
- EMIT: hold out_valid=1 with stable out_ch/out_data until out_valid&&out_ready.
  - On the accepting cycle, out_valid drops in the same clock edge. Increment the pointer and go to FIND.
  - While out_ready stays low, the FSM stalls indefinitely and no DRP traffic is issued.
- scan_start while busy sets pending (one deep). Further pulses are lost. Pending triggers one new scan after IDLE is reached.
- drp_drdy outside WAIT is ignored.
- CH_MASK=0: a scan passes through FIND straight back to IDLE. busy is high for the FIND cycles only, and no DRP access is made.
- Pointer width is 5 bits internally so that passing 15 is detectable without aliasing to 0.
- rd_data is registered from bank[rd_ch]. A bank write and a read of the same index in one cycle returns the old value; the new value appears on the next cycle.
- Asserting rst mid-transaction aborts immediately. Any DRP response arriving after reset is ignored.

Optional Feature:
VOLTMETER_AVG_EN defined:
- Each channel has an accumulator of 12+AVG_LOG2 bits and a sample counter.
- STORE adds the sample. Only when 2^AVG_LOG2 samples have been collected:
  - bank[ptr] = sum >> AVG_LOG2 (truncating), then the accumulator and counter clear and EMIT runs.
- Otherwise STORE goes directly to FIND (pointer incremented) and no record is emitted.
- A timeout does not advance the sample counter.

VOLTMETER_AVG_EN undefined:
- Every sample is stored and emitted.
- No accumulators are synthesised.

Decomposition:
- Shared package voltmeter_pkg holds:
  - FSM state encoding
  - XADC_AUX_BASE = 7'h10
  - ADC_W = 12
  - CH_IDX_W = 4
- One natural sub-module: xadc_ch_accum. It holds the per-channel accumulators and sample counters and is instantiated only under VOLTMETER_AVG_EN.

Test Plan:
- CH_MASK=16'h0005, out_ready=1, DRP model answers in 3 cycles with drp_do=16'hABC0/16'h1230 -> records (0,12'hABC) then (2,12'h123); daddr sequence 7'h10, 7'h12; busy returns to 0.
- out_ready held 0 for 50 cycles during EMIT -> out_valid, out_ch and out_data stay stable; drp_den stays 0; the record is accepted on the first cycle out_ready=1.
- DRP model never answers on channel 1 -> err_timeout=1 after TIMEOUT cycles; bank[1] unchanged; the scan continues with channel 2.
- Two scan_start pulses while busy -> exactly one extra scan follows the current one.
- VOLTMETER_AVG_EN, AVG_LOG2=2, channel 0 samples 100, 101, 102, 104 -> one record (0,101) after the fourth sample only.
- rst low asserted while in WAIT -> all outputs 0 asynchronously; a late drp_drdy after release produces no record.

Source files
------------

// File: rtl/voltmeter_pkg.sv
// Shared types and constants for the XADC voltmeter scan path.
package voltmeter_pkg;

  localparam int unsigned ADC_W         = 12;
  localparam int unsigned CH_IDX_W      = 4;
  localparam int unsigned PTR_W         = CH_IDX_W + 1;
  localparam logic [6:0]  XADC_AUX_BASE = 7'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIND,
    ST_ISSUE,
    ST_WAIT,
    ST_STORE,
    ST_EMIT
  } scan_state_t;

endpackage

// File: rtl/xadc_ch_accum.sv
// Per-channel sample accumulators and counters; averages 2^AVG_LOG2 samples.
// Only instantiated when VOLTMETER_AVG_EN is defined.
module xadc_ch_accum
  import voltmeter_pkg::*;
#(
  parameter int unsigned NUM_CH   = 16,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CH_IDX_W-1:0] ch,
  input  logic [ADC_W-1:0]    sample,
  output logic                done_c,
  output logic [ADC_W-1:0]    avg_c
);

  localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [ACC_W-1:0] sum_c;

  // Sum includes the incoming sample so the final one is averaged in.
  always_comb begin
    sum_c  = acc_q[ch] + ACC_W'(sample);
    done_c = (cnt_q[ch] == CNT_W'((1 << AVG_LOG2) - 1));
    avg_c  = ADC_W'(sum_c >> AVG_LOG2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else if (en) begin
      if (done_c) begin
        acc_q[ch] <= '0;
        cnt_q[ch] <= '0;
      end else begin
        acc_q[ch] <= sum_c;
        cnt_q[ch] <= cnt_q[ch] + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/xadc_channel_scanner.sv
// Scans masked XADC aux channels over DRP, banks results, streams {ch,value} records.
// Optional averaging build: define VOLTMETER_AVG_EN.
module xadc_channel_scanner
  import voltmeter_pkg::*;
#(
  parameter int unsigned NUM_CH   = 16,
  parameter logic [15:0] CH_MASK  = 16'h1FFF,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_start,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_ch,
  output logic [11:0] out_data,
  input  logic [3:0]  rd_ch,
  output logic [11:0] rd_data,
  output logic        busy,
  output logic        err_timeout
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  scan_state_t      state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             pending_q, pending_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit_c;
  logic [ADC_W-1:0] cap_q;
  logic [ADC_W-1:0] bank_q [NUM_CH];
  logic [ADC_W-1:0] store_val_c;
  logic             store_emit_c;
  logic             store_en_c;

  logic             den_d, valid_d, busy_d, err_d;
  logic [6:0]       daddr_d;
  logic [3:0]       out_ch_d;
  logic [11:0]      out_data_d;
  logic             unused_drp_lsbs;

  assign drp_dwe         = 1'b0;
  assign unused_drp_lsbs = ^drp_do[3:0];
  assign store_en_c      = (state_q == ST_STORE);

`ifdef VOLTMETER_AVG_EN
  xadc_ch_accum #(
    .NUM_CH   (NUM_CH),
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .en     (store_en_c),
    .ch     (ptr_q[CH_IDX_W-1:0]),
    .sample (cap_q),
    .done_c (store_emit_c),
    .avg_c  (store_val_c)
  );
`else
  localparam int unsigned unused_avg_log2 = AVG_LOG2;
  assign store_emit_c = 1'b1;
  assign store_val_c  = cap_q;
`endif

  // State register and scan bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      pending_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      tmo_q     <= tmo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pending_d = pending_q;
    tmo_d     = tmo_q;
    tmo_hit_c = 1'b0;
    if (scan_start && (state_q != ST_IDLE)) pending_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (scan_start || pending_q) begin
          pending_d = 1'b0;
          ptr_d     = '0;
          state_d   = ST_FIND;
        end
      end
      ST_FIND: begin
        if (ptr_q >= PTR_W'(NUM_CH))            state_d = ST_IDLE;
        else if (CH_MASK[ptr_q[CH_IDX_W-1:0]])  state_d = ST_ISSUE;
        else                                    ptr_d   = ptr_q + PTR_W'(1);
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (drp_drdy) begin
          state_d = ST_STORE;
        end else if (tmo_q >= TMO_W'(TIMEOUT - 1)) begin
          tmo_hit_c = 1'b1;
          ptr_d     = ptr_q + PTR_W'(1);
          state_d   = ST_FIND;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_STORE: begin
        if (store_emit_c) begin
          state_d = ST_EMIT;
        end else begin
          ptr_d   = ptr_q + PTR_W'(1);
          state_d = ST_FIND;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          ptr_d   = ptr_q + PTR_W'(1);
          state_d = ST_FIND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so registered outputs align with state_q.
  always_comb begin
    den_d      = (state_d == ST_ISSUE);
    daddr_d    = (state_d == ST_ISSUE) ? (XADC_AUX_BASE + 7'(ptr_d)) : drp_daddr;
    valid_d    = (state_d == ST_EMIT);
    busy_d     = (state_d != ST_IDLE);
    err_d      = err_timeout | tmo_hit_c;
    out_ch_d   = store_en_c ? ptr_q[CH_IDX_W-1:0] : out_ch;
    out_data_d = store_en_c ? store_val_c : out_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drp_den     <= 1'b0;
      drp_daddr   <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      out_ch      <= '0;
      out_data    <= '0;
    end else begin
      drp_den     <= den_d;
      drp_daddr   <= daddr_d;
      out_valid   <= valid_d;
      busy        <= busy_d;
      err_timeout <= err_d;
      out_ch      <= out_ch_d;
      out_data    <= out_data_d;
    end
  end

  // Capture, result bank and registered readback (read-before-write on collision).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q   <= '0;
      rd_data <= '0;
      for (int i = 0; i < NUM_CH; i++) bank_q[i] <= '0;
    end else begin
      if ((state_q == ST_WAIT) && drp_drdy) cap_q <= drp_do[15:4];
      if (store_en_c && store_emit_c) bank_q[ptr_q[CH_IDX_W-1:0]] <= store_val_c;
      rd_data <= bank_q[rd_ch];
    end
  end

endmodule

// File: tb/tb_xadc_channel_scanner.sv
// Scoreboard bench for xadc_channel_scanner: DRP responder model, record monitor, scenario tasks.
module tb_xadc_channel_scanner;

  localparam int unsigned TMO   = 40;
  localparam int unsigned DLY   = 3;
  localparam int unsigned AVG_L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scan_start = 1'b0;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_do = '0;
  logic        drp_drdy = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_ch;
  logic [11:0] out_data;
  logic [3:0]  rd_ch = '0;
  logic [11:0] rd_data;
  logic        busy, err_timeout;

  typedef struct { logic [3:0] ch; logic [11:0] data; } rec_t;

  int          errors = 0;
  int          checks = 0;
  rec_t        exp_q[$];
  logic [6:0]  addr_log[$];
  int          rec_count = 0;
  int          ch0_recs = 0;
  int          push_count = 0;
  logic [11:0] drp_val [16];
  logic [15:0] mute = '0;
  bit          push_en = 1'b1;
  logic [11:0] bank_m [16];
  int          acc_m [16];
  int          cnt_m [16];
  int          pend = 0;
  int          pend_ch = 0;

  xadc_channel_scanner #(
    .NUM_CH   (16),
    .CH_MASK  (16'h0007),
    .TIMEOUT  (TMO),
    .AVG_LOG2 (AVG_L)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .scan_start  (scan_start),
    .drp_daddr   (drp_daddr),
    .drp_den     (drp_den),
    .drp_dwe     (drp_dwe),
    .drp_do      (drp_do),
    .drp_drdy    (drp_drdy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_data    (out_data),
    .rd_ch       (rd_ch),
    .rd_data     (rd_data),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // DRP responder: answers DLY cycles after den and pushes the expected record.
  initial begin
    for (int i = 0; i < 16; i++) begin
      drp_val[i] = '0; bank_m[i] = '0; acc_m[i] = 0; cnt_m[i] = 0;
    end
    forever begin
      @(negedge clk);
      drp_drdy = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          drp_drdy = 1'b1;
          drp_do   = {drp_val[pend_ch], 4'h0};
          if (push_en) begin
`ifdef VOLTMETER_AVG_EN
            acc_m[pend_ch] += int'(drp_val[pend_ch]);
            cnt_m[pend_ch]++;
            if (cnt_m[pend_ch] == (1 << AVG_L)) begin
              bank_m[pend_ch] = 12'(acc_m[pend_ch] >> AVG_L);
              exp_q.push_back('{4'(pend_ch), bank_m[pend_ch]});
              push_count++;
              acc_m[pend_ch] = 0;
              cnt_m[pend_ch] = 0;
            end
`else
            bank_m[pend_ch] = drp_val[pend_ch];
            exp_q.push_back('{4'(pend_ch), drp_val[pend_ch]});
            push_count++;
`endif
          end
        end
      end
      #1;
      if (drp_den === 1'b1) begin
        addr_log.push_back(drp_daddr);
        pend_ch = int'(drp_daddr - 7'h10) & 15;
        if (!mute[pend_ch]) pend = DLY;
      end
    end
  end

  // Record monitor: pops the scoreboard on every accepted record.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk); #1;
      if (rst && out_valid === 1'b1 && out_ready === 1'b1) begin
        rec_count++;
        if (out_ch == 4'd0) ch0_recs++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL record_unexpected got ch=%0d data=%h, expected no record", out_ch, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_ch !== e.ch || out_data !== e.data) begin
            errors++;
            $display("FAIL record got ch=%0d data=%h, expected ch=%0d data=%h", out_ch, out_data, e.ch, e.data);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_scan();
    @(negedge clk); scan_start = 1'b1;
    @(negedge clk); scan_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [40:0] outs;
    rst = 1'b0;
    tick(2); #1;
    outs = {drp_den, drp_daddr, out_valid, out_ch, out_data, rd_data, busy, err_timeout};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs got %h, expected 0", outs);
    end
    checks++;
    if (drp_dwe !== 1'b0) begin
      errors++; $display("FAIL reset_dwe got %b, expected 0", drp_dwe);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_scan_basic();
    bit ok;
    int r0, p0;
    drp_val[0] = 12'hABC; drp_val[1] = 12'h5A5; drp_val[2] = 12'h123;
    out_ready = 1'b1;
    addr_log.delete();
    r0 = rec_count; p0 = push_count;
    pulse_scan();
    wait_idle(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_busy got busy=%b, expected 0", busy); end
    checks++;
    if (addr_log.size() != 3 || addr_log[0] !== 7'h10 || addr_log[1] !== 7'h11 || addr_log[2] !== 7'h12) begin
      errors++; $display("FAIL basic_daddr got %0d accesses first=%h, expected 10,11,12", addr_log.size(),
                         (addr_log.size() > 0) ? addr_log[0] : 7'h0);
    end
    checks++;
    if (exp_q.size() != 0 || (rec_count - r0) != (push_count - p0)) begin
      errors++; $display("FAIL basic_records got %0d records, expected %0d", rec_count - r0, push_count - p0);
    end
`ifndef VOLTMETER_AVG_EN
    checks++;
    if ((rec_count - r0) != 3) begin
      errors++; $display("FAIL basic_count got %0d, expected 3", rec_count - r0);
    end
`endif
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); rd_ch = 4'(c);
      @(negedge clk); #1;
      checks++;
      if (rd_data !== bank_m[c]) begin
        errors++; $display("FAIL readback ch%0d got %h, expected %h", c, rd_data, bank_m[c]);
      end
    end
  endtask

  task automatic test_stall();
    bit ok, seen, bad;
    logic [3:0] sch; logic [11:0] sdat;
    int r0;
    drp_val[0] = 12'h111; drp_val[1] = 12'h222; drp_val[2] = 12'h333;
    @(negedge clk); out_ready = 1'b0;
    pulse_scan();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (out_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_valid got out_valid=0, expected 1"); end
    sch = out_ch; sdat = out_data;
    checks++;
    if (exp_q.size() == 0 || sch !== exp_q[0].ch || sdat !== exp_q[0].data) begin
      errors++; $display("FAIL stall_record got ch=%0d data=%h, expected ch=0 data=111", sch, sdat);
    end
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (out_valid !== 1'b1 || out_ch !== sch || out_data !== sdat || drp_den !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL stall_stable got change during stall, expected stable and den=0"); end
    r0 = rec_count;
    @(negedge clk); out_ready = 1'b1;
    #2;
    checks++;
    if (rec_count != r0 + 1) begin
      errors++; $display("FAIL stall_accept got %0d accepts, expected 1", rec_count - r0);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drop got out_valid=%b, expected 0", out_valid); end
    wait_idle(400, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_finish got busy=%b pending=%0d, expected 0/0", busy, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    #1;
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_pre got %b, expected 0", err_timeout); end
    mute = 16'h0002;
    drp_val[0] = 12'h0F0; drp_val[1] = 12'hEEE; drp_val[2] = 12'h00F;
    addr_log.delete();
    pulse_scan();
    wait_idle(600, ok);
    checks++;
    if (!ok || err_timeout !== 1'b1) begin
      errors++; $display("FAIL tmo_flag got busy=%b err=%b, expected 0/1", busy, err_timeout);
    end
    checks++;
    if (addr_log.size() != 3 || addr_log[2] !== 7'h12) begin
      errors++; $display("FAIL tmo_continue got %0d accesses, expected 3 ending at 12", addr_log.size());
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL tmo_records got %0d left, expected 0", exp_q.size()); end
    @(negedge clk); rd_ch = 4'd1;
    @(negedge clk); #1;
    checks++;
    if (rd_data !== bank_m[1]) begin
      errors++; $display("FAIL tmo_bank1 got %h, expected %h", rd_data, bank_m[1]);
    end
    mute = '0;
  endtask

  task automatic test_back_to_back();
    bit done;
    addr_log.delete();
    pulse_scan();
    tick(3);
    pulse_scan();
    tick(2);
    pulse_scan();
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (addr_log.size() >= 6) begin done = 1'b1; break; end
    end
    tick(150); #1;
    checks++;
    if (!done || addr_log.size() != 6 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_scans got %0d accesses busy=%b, expected 6/0", addr_log.size(), busy);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_records got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [21:0] outs;
    int r0;
    push_en = 1'b0;
    addr_log.delete();
    pulse_scan();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (addr_log.size() > 0) begin seen = 1'b1; break; end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    outs = {drp_den, out_valid, busy, err_timeout, out_ch, out_data, 2'b00};
    checks++;
    if (!seen || outs !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got %h seen=%b, expected 0/1", outs, seen);
    end
    for (int i = 0; i < 16; i++) begin bank_m[i] = '0; acc_m[i] = 0; cnt_m[i] = 0; end
    r0 = rec_count;
    @(negedge clk); rst = 1'b1;
    tick(20); #1;
    checks++;
    if (rec_count != r0 || busy !== 1'b0 || addr_log.size() != 1) begin
      errors++; $display("FAIL rst_mid_late got %0d records busy=%b acc=%0d, expected 0/0/1",
                         rec_count - r0, busy, addr_log.size());
    end
    @(negedge clk); rd_ch = 4'd0;
    @(negedge clk); #1;
    checks++;
    if (rd_data !== 12'h000) begin errors++; $display("FAIL rst_mid_bank got %h, expected 000", rd_data); end
    push_en = 1'b1;
  endtask

`ifdef VOLTMETER_AVG_EN
  task automatic test_avg();
    bit ok;
    int c0;
    logic [11:0] samples [4];
    samples[0] = 12'd100; samples[1] = 12'd101; samples[2] = 12'd102; samples[3] = 12'd104;
    c0 = ch0_recs;
    for (int s = 0; s < 4; s++) begin
      drp_val[0] = samples[s];
      pulse_scan();
      wait_idle(400, ok);
      checks++;
      if ((ch0_recs - c0) != ((s == 3) ? 1 : 0)) begin
        errors++; $display("FAIL avg_count after %0d samples got %0d, expected %0d", s + 1, ch0_recs - c0, (s == 3) ? 1 : 0);
      end
    end
    @(negedge clk); rd_ch = 4'd0;
    @(negedge clk); #1;
    checks++;
    if (rd_data !== 12'd101) begin errors++; $display("FAIL avg_value got %0d, expected 101", rd_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_scan_basic();
    test_stall();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
`ifdef VOLTMETER_AVG_EN
    test_avg();
`endif
    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
